// File: rtl/risc_pkg.sv
// Shared definitions for the RISC core pipeline: instruction kinds seen by writeback,
// writeback state encoding and default datapath sizes.
package risc_pkg;

  localparam int DATA_W_DEF       = 32;
  localparam int REG_AW_DEF       = 4;
  localparam int LOAD_TIMEOUT_DEF = 15;

  typedef enum logic [1:0] {
    KIND_NONE = 2'd0,
    KIND_ALU  = 2'd1,
    KIND_LOAD = 2'd2,
    KIND_CALL = 2'd3
  } ex_kind_e;

  typedef enum logic {
    WB_IDLE      = 1'b0,
    WB_LOAD_WAIT = 1'b1
  } wb_state_e;

endpackage

// File: rtl/wb_stage_if.sv
// Bundle of the writeback stage's execute handshake, data-memory load port,
// register-bank write port and forwarding bypass.
interface wb_stage_if import risc_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_AW = REG_AW_DEF
);

  logic              ex_valid;
  logic              ex_ready;
  ex_kind_e          ex_kind;
  logic [REG_AW-1:0] ex_rd;
  logic [DATA_W-1:0] ex_result;
  logic [DATA_W-1:0] ex_link;

  logic              mem_req;
  logic [DATA_W-1:0] mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  logic              wr_reg;
  logic              wr_is_call;
  logic [REG_AW-1:0] wr_rd;
  logic [DATA_W-1:0] wr_data;

  logic              fwd_valid;
  logic [REG_AW-1:0] fwd_rd;
  logic [DATA_W-1:0] fwd_data;

  logic              load_err;

  // master is the writeback stage itself; slave is its surroundings
  modport master (
    input  ex_valid, ex_kind, ex_rd, ex_result, ex_link, mem_ack, mem_rdata,
    output ex_ready, mem_req, mem_addr, wr_reg, wr_is_call, wr_rd, wr_data,
           fwd_valid, fwd_rd, fwd_data, load_err
  );

  modport slave (
    output ex_valid, ex_kind, ex_rd, ex_result, ex_link, mem_ack, mem_rdata,
    input  ex_ready, mem_req, mem_addr, wr_reg, wr_is_call, wr_rd, wr_data,
           fwd_valid, fwd_rd, fwd_data, load_err
  );

endinterface

// File: rtl/wb_load_ctrl.sv
// Load side of writeback: holds the memory request until ack or timeout and
// reports completion (or a sticky timeout error) to the stage.
module wb_load_ctrl import risc_pkg::*; #(
  parameter int DATA_W       = DATA_W_DEF,
  parameter int REG_AW       = REG_AW_DEF,
  parameter int LOAD_TIMEOUT = LOAD_TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_i,
  input  logic [REG_AW-1:0] rd_i,
  input  logic [DATA_W-1:0] addr_i,
  input  logic              mem_ack_i,
  output logic              busy_o,
  output logic              mem_req_o,
  output logic [DATA_W-1:0] mem_addr_o,
  output logic              done_o,
  output logic [REG_AW-1:0] done_rd_o,
  output logic              load_err_o
);

  localparam int               CNT_W    = $clog2(LOAD_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOAD_TIMEOUT - 1);

  wb_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic              err_q, err_d;

  // An ack on the last permitted cycle is checked first, so it beats the timeout.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    addr_d  = addr_q;
    err_d   = err_q;
    done_o  = 1'b0;
    case (state_q)
      WB_IDLE: begin
        if (start_i) begin
          state_d = WB_LOAD_WAIT;
          cnt_d   = '0;
          rd_d    = rd_i;
          addr_d  = addr_i;
        end
      end
      WB_LOAD_WAIT: begin
        if (mem_ack_i) begin
          done_o  = 1'b1;
          state_d = WB_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            err_d   = 1'b1;
            state_d = WB_IDLE;
          end
        end
      end
      default: state_d = WB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= WB_IDLE;
      cnt_q   <= '0;
      rd_q    <= '0;
      addr_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
    end
  end

  assign busy_o     = (state_q == WB_LOAD_WAIT);
  assign mem_req_o  = busy_o;
  assign mem_addr_o = addr_q;
  assign done_rd_o  = rd_q;
  assign load_err_o = err_q;

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: retires ALU/CALL results directly and loads via wb_load_ctrl,
// driving a registered register-bank write port and a same-cycle forwarding bypass.
module wb_stage import risc_pkg::*; #(
  parameter int DATA_W       = DATA_W_DEF,
  parameter int REG_AW       = REG_AW_DEF,
  parameter int LOAD_TIMEOUT = LOAD_TIMEOUT_DEF
) (
  input  logic       clk,
  input  logic       reset,
  wb_stage_if.master bus
);

  logic              busy;
  logic              accept;
  logic              start_load;
  logic              ld_done;
  logic [REG_AW-1:0] ld_rd;

  logic              wr_reg_q, wr_reg_d;
  logic              wr_call_q, wr_call_d;
  logic [REG_AW-1:0] wr_rd_q, wr_rd_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;

  assign bus.ex_ready = !busy;
  assign accept       = bus.ex_valid && !busy;
  assign start_load   = accept && (bus.ex_kind == KIND_LOAD);

  wb_load_ctrl #(
    .DATA_W       (DATA_W),
    .REG_AW       (REG_AW),
    .LOAD_TIMEOUT (LOAD_TIMEOUT)
  ) u_load_ctrl (
    .clk        (clk),
    .reset      (reset),
    .start_i    (start_load),
    .rd_i       (bus.ex_rd),
    .addr_i     (bus.ex_result),
    .mem_ack_i  (bus.mem_ack),
    .busy_o     (busy),
    .mem_req_o  (bus.mem_req),
    .mem_addr_o (bus.mem_addr),
    .done_o     (ld_done),
    .done_rd_o  (ld_rd),
    .load_err_o (bus.load_err)
  );

  // Load completion and a new accept never coincide: ex_ready is low while a load waits.
  always_comb begin
    wr_reg_d  = 1'b0;
    wr_call_d = 1'b0;
    wr_rd_d   = wr_rd_q;
    wr_data_d = wr_data_q;
    if (ld_done) begin
      if (ld_rd != '0) begin
        wr_reg_d  = 1'b1;
        wr_rd_d   = ld_rd;
        wr_data_d = bus.mem_rdata;
      end
    end else if (accept) begin
      case (bus.ex_kind)
        KIND_ALU: begin
          if (bus.ex_rd != '0) begin
            wr_reg_d  = 1'b1;
            wr_rd_d   = bus.ex_rd;
            wr_data_d = bus.ex_result;
          end
        end
        KIND_CALL: begin
          wr_reg_d  = 1'b1;
          wr_call_d = 1'b1;
          wr_rd_d   = bus.ex_rd;
          wr_data_d = bus.ex_link;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_reg_q  <= 1'b0;
      wr_call_q <= 1'b0;
      wr_rd_q   <= '0;
      wr_data_q <= '0;
    end else begin
      wr_reg_q  <= wr_reg_d;
      wr_call_q <= wr_call_d;
      wr_rd_q   <= wr_rd_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign bus.wr_reg     = wr_reg_q;
  assign bus.wr_is_call = wr_call_q;
  assign bus.wr_rd      = wr_rd_q;
  assign bus.wr_data    = wr_data_q;

  // Return-address writes go to a dedicated register, so they are not forwarded.
  assign bus.fwd_valid = wr_reg_q && !wr_call_q;
  assign bus.fwd_rd    = wr_rd_q;
  assign bus.fwd_data  = wr_data_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage: ALU/CALL writes, load handshake,
// timeout boundary, spurious acks and reset during a pending load.
module tb_wb_stage import risc_pkg::*;;

  logic clk;
  logic reset;
  int   testCount;
  int   failCount;
  int   reqCycles;
  logic sawWrite;

  wb_stage_if #(.DATA_W(32), .REG_AW(4)) bus ();

  wb_stage #(
    .DATA_W       (32),
    .REG_AW       (4),
    .LOAD_TIMEOUT (15)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input ex_kind_e k, input logic [3:0] rd,
                               input logic [31:0] res, input logic [31:0] link);
    bus.ex_valid  = v;
    bus.ex_kind   = k;
    bus.ex_rd     = rd;
    bus.ex_result = res;
    bus.ex_link   = link;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  initial begin
    testCount = 0;
    failCount = 0;
    reset = 1'b1;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    applyStimulus(1'b0, KIND_NONE, 4'd0, 32'h0, 32'h0);
    tick();

    checkOutput("rst_ex_ready", 32'(bus.ex_ready), 32'd1);
    checkOutput("rst_mem_req", 32'(bus.mem_req), 32'd0);
    checkOutput("rst_mem_addr", bus.mem_addr, 32'd0);
    checkOutput("rst_wr_reg", 32'(bus.wr_reg), 32'd0);
    checkOutput("rst_wr_is_call", 32'(bus.wr_is_call), 32'd0);
    checkOutput("rst_wr_rd", 32'(bus.wr_rd), 32'd0);
    checkOutput("rst_wr_data", bus.wr_data, 32'd0);
    checkOutput("rst_fwd_valid", 32'(bus.fwd_valid), 32'd0);
    checkOutput("rst_fwd_data", bus.fwd_data, 32'd0);
    checkOutput("rst_load_err", 32'(bus.load_err), 32'd0);

    reset = 1'b0;
    tick();

    // ALU rd=5
    applyStimulus(1'b1, KIND_ALU, 4'd5, 32'h1234_5678, 32'h0);
    tick();
    applyStimulus(1'b0, KIND_NONE, 4'd0, 32'h0, 32'h0);
    checkOutput("alu_wr_reg", 32'(bus.wr_reg), 32'd1);
    checkOutput("alu_wr_rd", 32'(bus.wr_rd), 32'd5);
    checkOutput("alu_wr_data", bus.wr_data, 32'h1234_5678);
    checkOutput("alu_wr_is_call", 32'(bus.wr_is_call), 32'd0);
    checkOutput("alu_fwd_valid", 32'(bus.fwd_valid), 32'd1);
    checkOutput("alu_fwd_rd", 32'(bus.fwd_rd), 32'd5);
    checkOutput("alu_fwd_data", bus.fwd_data, 32'h1234_5678);
    tick();
    checkOutput("alu_pulse_end", 32'(bus.wr_reg), 32'd0);
    checkOutput("alu_fwd_end", 32'(bus.fwd_valid), 32'd0);

    // ALU to R0 is dropped
    applyStimulus(1'b1, KIND_ALU, 4'd0, 32'hFFFF_FFFF, 32'h0);
    tick();
    applyStimulus(1'b0, KIND_NONE, 4'd0, 32'h0, 32'h0);
    checkOutput("alu_r0_wr_reg", 32'(bus.wr_reg), 32'd0);

    // CALL to R0 still writes, not forwarded
    applyStimulus(1'b1, KIND_CALL, 4'd0, 32'h0, 32'h40);
    tick();
    applyStimulus(1'b0, KIND_NONE, 4'd0, 32'h0, 32'h0);
    checkOutput("call_wr_reg", 32'(bus.wr_reg), 32'd1);
    checkOutput("call_is_call", 32'(bus.wr_is_call), 32'd1);
    checkOutput("call_wr_data", bus.wr_data, 32'h40);
    checkOutput("call_wr_rd", 32'(bus.wr_rd), 32'd0);
    checkOutput("call_fwd_valid", 32'(bus.fwd_valid), 32'd0);
    tick();

    // NONE is consumed without a write
    applyStimulus(1'b1, KIND_NONE, 4'd3, 32'hABCD, 32'h0);
    tick();
    applyStimulus(1'b0, KIND_NONE, 4'd0, 32'h0, 32'h0);
    checkOutput("none_wr_reg", 32'(bus.wr_reg), 32'd0);

    // back-to-back ALU
    applyStimulus(1'b1, KIND_ALU, 4'd1, 32'hA, 32'h0);
    tick();
    checkOutput("b2b1_wr_reg", 32'(bus.wr_reg), 32'd1);
    checkOutput("b2b1_wr_rd", 32'(bus.wr_rd), 32'd1);
    applyStimulus(1'b1, KIND_ALU, 4'd2, 32'hB, 32'h0);
    tick();
    applyStimulus(1'b0, KIND_NONE, 4'd0, 32'h0, 32'h0);
    checkOutput("b2b2_wr_reg", 32'(bus.wr_reg), 32'd1);
    checkOutput("b2b2_wr_rd", 32'(bus.wr_rd), 32'd2);
    checkOutput("b2b2_wr_data", bus.wr_data, 32'hB);
    tick();
    checkOutput("b2b_end", 32'(bus.wr_reg), 32'd0);

    // LOAD rd=7 addr 0x100, ack in the third request cycle
    applyStimulus(1'b1, KIND_LOAD, 4'd7, 32'h100, 32'h0);
    tick();
    applyStimulus(1'b0, KIND_NONE, 4'd0, 32'h0, 32'h0);
    checkOutput("ld_req1", 32'(bus.mem_req), 32'd1);
    checkOutput("ld_addr1", bus.mem_addr, 32'h100);
    checkOutput("ld_ready1", 32'(bus.ex_ready), 32'd0);
    checkOutput("ld_nowr1", 32'(bus.wr_reg), 32'd0);
    tick();
    checkOutput("ld_req2", 32'(bus.mem_req), 32'd1);
    tick();
    checkOutput("ld_req3", 32'(bus.mem_req), 32'd1);
    checkOutput("ld_addr3", bus.mem_addr, 32'h100);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hDEAD_BEEF;
    tick();
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'h0;
    checkOutput("ld_req_drop", 32'(bus.mem_req), 32'd0);
    checkOutput("ld_wr_reg", 32'(bus.wr_reg), 32'd1);
    checkOutput("ld_wr_rd", 32'(bus.wr_rd), 32'd7);
    checkOutput("ld_wr_data", bus.wr_data, 32'hDEAD_BEEF);
    checkOutput("ld_fwd_valid", 32'(bus.fwd_valid), 32'd1);
    checkOutput("ld_ready_back", 32'(bus.ex_ready), 32'd1);
    applyStimulus(1'b1, KIND_ALU, 4'd3, 32'h33, 32'h0);
    tick();
    applyStimulus(1'b0, KIND_NONE, 4'd0, 32'h0, 32'h0);
    checkOutput("post_ld_wr_reg", 32'(bus.wr_reg), 32'd1);
    checkOutput("post_ld_wr_rd", 32'(bus.wr_rd), 32'd3);
    checkOutput("post_ld_wr_data", bus.wr_data, 32'h33);
    tick();

    // ack on the 15th request cycle wins over the timeout
    applyStimulus(1'b1, KIND_LOAD, 4'd9, 32'h300, 32'h0);
    tick();
    applyStimulus(1'b0, KIND_NONE, 4'd0, 32'h0, 32'h0);
    for (int i = 0; i < 14; i++) tick();
    checkOutput("bnd_req_last", 32'(bus.mem_req), 32'd1);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h5A5A_0001;
    tick();
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'h0;
    checkOutput("bnd_wr_reg", 32'(bus.wr_reg), 32'd1);
    checkOutput("bnd_wr_rd", 32'(bus.wr_rd), 32'd9);
    checkOutput("bnd_wr_data", bus.wr_data, 32'h5A5A_0001);
    checkOutput("bnd_load_err", 32'(bus.load_err), 32'd0);
    checkOutput("bnd_req_drop", 32'(bus.mem_req), 32'd0);
    tick();

    // spurious ack while idle
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h7777_7777;
    tick();
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'h0;
    checkOutput("spur_wr_reg", 32'(bus.wr_reg), 32'd0);
    checkOutput("spur_mem_req", 32'(bus.mem_req), 32'd0);

    // LOAD with no ack times out after 15 request cycles
    applyStimulus(1'b1, KIND_LOAD, 4'd4, 32'h200, 32'h0);
    tick();
    applyStimulus(1'b0, KIND_NONE, 4'd0, 32'h0, 32'h0);
    reqCycles = 0;
    sawWrite  = 1'b0;
    for (int i = 0; i < 40 && bus.mem_req; i++) begin
      reqCycles++;
      if (bus.wr_reg) sawWrite = 1'b1;
      tick();
    end
    checkOutput("to_req_cycles", 32'(reqCycles), 32'd15);
    checkOutput("to_no_write", 32'(sawWrite | bus.wr_reg), 32'd0);
    checkOutput("to_load_err", 32'(bus.load_err), 32'd1);
    checkOutput("to_ready_back", 32'(bus.ex_ready), 32'd1);
    applyStimulus(1'b1, KIND_ALU, 4'd8, 32'h88, 32'h0);
    tick();
    applyStimulus(1'b0, KIND_NONE, 4'd0, 32'h0, 32'h0);
    tick();
    checkOutput("to_err_sticky", 32'(bus.load_err), 32'd1);

    // reset during LOAD_WAIT
    applyStimulus(1'b1, KIND_LOAD, 4'd6, 32'h400, 32'h0);
    tick();
    applyStimulus(1'b0, KIND_NONE, 4'd0, 32'h0, 32'h0);
    checkOutput("mid_req", 32'(bus.mem_req), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("mid_rst_req", 32'(bus.mem_req), 32'd0);
    checkOutput("mid_rst_addr", bus.mem_addr, 32'd0);
    checkOutput("mid_rst_ready", 32'(bus.ex_ready), 32'd1);
    checkOutput("mid_rst_err", 32'(bus.load_err), 32'd0);
    checkOutput("mid_rst_wr_data", bus.wr_data, 32'd0);
    checkOutput("mid_rst_wr_rd", 32'(bus.wr_rd), 32'd0);
    tick();
    tick();
    reset = 1'b0;
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h1111_2222;
    tick();
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'h0;
    checkOutput("post_rst_no_ld_wr", 32'(bus.wr_reg), 32'd0);
    applyStimulus(1'b1, KIND_ALU, 4'd2, 32'd9, 32'h0);
    tick();
    applyStimulus(1'b0, KIND_NONE, 4'd0, 32'h0, 32'h0);
    checkOutput("post_rst_wr_reg", 32'(bus.wr_reg), 32'd1);
    checkOutput("post_rst_wr_rd", 32'(bus.wr_rd), 32'd2);
    checkOutput("post_rst_wr_data", bus.wr_data, 32'd9);
    tick();

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
